// File: rtl/aidc_lite_comp_select.sv
// Purpose: two-bank selector that emits each 8-beat block either as its compressed words or as raw beats.
// Latency: valid_o rises the cycle after a bank becomes FULL, then one word per handshake, with no bubble between banks.
// Backpressure: ready_i stalls the output register, and a sop that finds its bank busy drops the block and pulses overflow_o.
// Optional: define AIDC_LITE_SELECT_STATS_EN to add the cnt_comp_o/cnt_raw_o block counters.
module aidc_lite_comp_select (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic        sop_i,
  input  logic        eop_i,
  input  logic [63:0] data_i,
  input  logic        comp_valid_i,
  input  logic [3:0]  comp_addr_i,
  input  logic [63:0] comp_data_i,
  input  logic        comp_eop_i,
  input  logic        comp_fail_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        sop_o,
  output logic        eop_o,
  output logic [63:0] data_o,
  output logic        comp_o,
  output logic [3:0]  len_o,
  output logic        overflow_o
`ifdef AIDC_LITE_SELECT_STATS_EN
  ,
  output logic [15:0] cnt_comp_o,
  output logic [15:0] cnt_raw_o
`endif
);

  typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_FULL, ST_DRAIN} bank_st_e;

  // Per-bank control
  bank_st_e    st_q[2], st_d[2];
  logic        raw_done_q[2], raw_done_d[2];
  logic        comp_done_q[2], comp_done_d[2];
  logic        fail_q[2], fail_d[2];
  logic [3:0]  len_q[2], len_d[2];

  // Bank storage (data only, no reset needed)
  logic [63:0] raw_mem[2][8];
  logic [63:0] comp_mem[2][8];

  // Write side
  logic        raw_ptr_q, raw_ptr_d;
  logic [3:0]  raw_idx_q, raw_idx_d;
  logic        raw_we;
  logic [2:0]  raw_waddr;
  logic        comp_ptr_q, comp_ptr_d;
  logic        comp_we;
  logic [2:0]  acc_max_q, acc_max_d, acc_max_n;
  logic        acc_bad_q, acc_bad_d, acc_bad_n;

  // Tag FIFO: one kept(1)/dropped(0) entry per block-starting sop
  logic [3:0]  tag_mem_q, tag_mem_d;
  logic [1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [2:0]  tag_cnt_q, tag_cnt_d;
  logic        tag_push, tag_push_val, tag_push_ok, tag_pop, head_kept;

  // Read side and registered outputs
  logic        rd_ptr_q, rd_ptr_d;
  logic [2:0]  rd_idx_q, rd_idx_d;
  logic        rd_avail, rd_last;
  logic        out_bank_q, out_bank_d;
  logic        out_valid_q, out_valid_d;
  logic        out_sop_q, out_sop_d;
  logic        out_eop_q, out_eop_d;
  logic        out_comp_q, out_comp_d;
  logic [3:0]  out_len_q, out_len_d;
  logic [63:0] out_data_q, out_data_d;
  logic        ovf_q, ovf_d;

  // Next-state for bank control, tag FIFO, write pointers and the output register
  always_comb begin
    st_d         = st_q;
    raw_done_d   = raw_done_q;
    comp_done_d  = comp_done_q;
    fail_d       = fail_q;
    len_d        = len_q;
    raw_ptr_d    = raw_ptr_q;
    raw_idx_d    = raw_idx_q;
    raw_we       = 1'b0;
    raw_waddr    = raw_idx_q[2:0];
    comp_ptr_d   = comp_ptr_q;
    comp_we      = 1'b0;
    acc_max_n    = acc_max_q;
    acc_bad_n    = acc_bad_q;
    acc_max_d    = acc_max_q;
    acc_bad_d    = acc_bad_q;
    tag_mem_d    = tag_mem_q;
    tag_wr_d     = tag_wr_q;
    tag_rd_d     = tag_rd_q;
    tag_push     = 1'b0;
    tag_push_val = 1'b0;
    tag_push_ok  = 1'b0;
    tag_pop      = 1'b0;
    ovf_d        = 1'b0;
    rd_ptr_d     = rd_ptr_q;
    rd_idx_d     = rd_idx_q;
    rd_last      = 1'b0;
    out_bank_d   = out_bank_q;
    out_valid_d  = out_valid_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    out_comp_d   = out_comp_q;
    out_len_d    = out_len_q;
    out_data_d   = out_data_q;

    // Raw side: a bank accepts beats only while filling and not yet complete
    if (valid_i) begin
      if (sop_i) begin
        if (st_q[raw_ptr_q] == ST_EMPTY) begin
          st_d[raw_ptr_q]        = ST_FILL;
          raw_done_d[raw_ptr_q]  = 1'b0;
          comp_done_d[raw_ptr_q] = 1'b0;
          raw_we                 = 1'b1;
          raw_waddr              = 3'd0;
          raw_idx_d              = 4'd1;
          tag_push               = 1'b1;
          tag_push_val           = 1'b1;
        end else if (st_q[raw_ptr_q] == ST_FILL && !raw_done_q[raw_ptr_q]) begin
          // Restart the block in place; its tag is already queued
          raw_we    = 1'b1;
          raw_waddr = 3'd0;
          raw_idx_d = 4'd1;
        end else begin
          ovf_d        = 1'b1;
          tag_push     = 1'b1;
          tag_push_val = 1'b0;
        end
      end else if (st_q[raw_ptr_q] == ST_FILL && !raw_done_q[raw_ptr_q]) begin
        if (raw_idx_q < 4'd8) begin
          raw_we    = 1'b1;
          raw_idx_d = raw_idx_q + 4'd1;
        end
        if (eop_i && raw_idx_q == 4'd7) begin
          raw_done_d[raw_ptr_q] = 1'b1;
          raw_ptr_d             = ~raw_ptr_q;
        end
      end
    end

    // Compressed side: words belong to the block at the head of the tag FIFO
    head_kept = (tag_cnt_q != 3'd0) && tag_mem_q[tag_rd_q];
    if (comp_valid_i && head_kept) begin
      if (comp_addr_i[3]) begin
        acc_bad_n = 1'b1;
      end else begin
        comp_we = 1'b1;
        if (comp_addr_i[2:0] > acc_max_n) acc_max_n = comp_addr_i[2:0];
      end
    end
    acc_max_d = acc_max_n;
    acc_bad_d = acc_bad_n;
    if (comp_eop_i && tag_cnt_q != 3'd0) begin
      tag_pop = 1'b1;
      if (head_kept) begin
        fail_d[comp_ptr_q]      = comp_fail_i | acc_bad_n;
        len_d[comp_ptr_q]       = (comp_fail_i | acc_bad_n) ? 4'd8 : ({1'b0, acc_max_n} + 4'd1);
        comp_done_d[comp_ptr_q] = 1'b1;
        comp_ptr_d              = ~comp_ptr_q;
      end
      acc_max_d = 3'd0;
      acc_bad_d = 1'b0;
    end

    // Tag FIFO bookkeeping; a push into a full FIFO is only taken when a pop frees a slot
    tag_push_ok = tag_push && (tag_cnt_q != 3'd4 || tag_pop);
    if (tag_push_ok) begin
      tag_mem_d[tag_wr_q] = tag_push_val;
      tag_wr_d            = tag_wr_q + 2'd1;
    end
    if (tag_pop) tag_rd_d = tag_rd_q + 2'd1;
    tag_cnt_d = tag_cnt_q + {2'b0, tag_push_ok} - {2'b0, tag_pop};

    // A bank is FULL once both halves of the block have landed, in either order
    for (int b = 0; b < 2; b++) begin
      if (st_d[b] == ST_FILL && raw_done_d[b] && comp_done_d[b]) st_d[b] = ST_FULL;
    end

    // Free the bank whose last word handshakes this cycle
    if (out_valid_q && ready_i && out_eop_q) st_d[out_bank_q] = ST_EMPTY;

    // Refill the output register whenever it is empty or being consumed
    rd_avail = (rd_idx_q == 3'd0) ? (st_q[rd_ptr_q] == ST_FULL) : (st_q[rd_ptr_q] == ST_DRAIN);
    if (!out_valid_q || ready_i) begin
      if (rd_avail) begin
        rd_last          = (({1'b0, rd_idx_q} + 4'd1) == len_q[rd_ptr_q]);
        out_valid_d      = 1'b1;
        out_data_d       = fail_q[rd_ptr_q] ? raw_mem[rd_ptr_q][rd_idx_q] : comp_mem[rd_ptr_q][rd_idx_q];
        out_sop_d        = (rd_idx_q == 3'd0);
        out_eop_d        = rd_last;
        out_comp_d       = ~fail_q[rd_ptr_q];
        out_len_d        = len_q[rd_ptr_q];
        out_bank_d       = rd_ptr_q;
        st_d[rd_ptr_q]   = ST_DRAIN;
        if (rd_last) begin
          rd_idx_d = 3'd0;
          rd_ptr_d = ~rd_ptr_q;
        end else begin
          rd_idx_d = rd_idx_q + 3'd1;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]        <= ST_EMPTY;
        raw_done_q[b]  <= 1'b0;
        comp_done_q[b] <= 1'b0;
        fail_q[b]      <= 1'b0;
        len_q[b]       <= 4'd0;
      end
      raw_ptr_q   <= 1'b0;
      raw_idx_q   <= 4'd0;
      comp_ptr_q  <= 1'b0;
      acc_max_q   <= 3'd0;
      acc_bad_q   <= 1'b0;
      tag_mem_q   <= 4'd0;
      tag_wr_q    <= 2'd0;
      tag_rd_q    <= 2'd0;
      tag_cnt_q   <= 3'd0;
      rd_ptr_q    <= 1'b0;
      rd_idx_q    <= 3'd0;
      out_bank_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_comp_q  <= 1'b0;
      out_len_q   <= 4'd0;
      out_data_q  <= 64'd0;
      ovf_q       <= 1'b0;
    end else begin
      st_q        <= st_d;
      raw_done_q  <= raw_done_d;
      comp_done_q <= comp_done_d;
      fail_q      <= fail_d;
      len_q       <= len_d;
      raw_ptr_q   <= raw_ptr_d;
      raw_idx_q   <= raw_idx_d;
      comp_ptr_q  <= comp_ptr_d;
      acc_max_q   <= acc_max_d;
      acc_bad_q   <= acc_bad_d;
      tag_mem_q   <= tag_mem_d;
      tag_wr_q    <= tag_wr_d;
      tag_rd_q    <= tag_rd_d;
      tag_cnt_q   <= tag_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_idx_q    <= rd_idx_d;
      out_bank_q  <= out_bank_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_comp_q  <= out_comp_d;
      out_len_q   <= out_len_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
    end
  end

  // Bank payload storage
  always_ff @(posedge clk) begin
    if (raw_we) raw_mem[raw_ptr_q][raw_waddr] <= data_i;
    if (comp_we) comp_mem[comp_ptr_q][comp_addr_i[2:0]] <= comp_data_i;
  end

  assign valid_o    = out_valid_q;
  assign sop_o      = out_sop_q;
  assign eop_o      = out_eop_q;
  assign comp_o     = out_comp_q;
  assign len_o      = out_len_q;
  assign data_o     = out_data_q;
  assign overflow_o = ovf_q;

`ifdef AIDC_LITE_SELECT_STATS_EN
  logic [15:0] cnt_comp_q, cnt_comp_d, cnt_raw_q, cnt_raw_d;

  // Saturating per-kind block counters, bumped on each block's final handshake
  always_comb begin
    cnt_comp_d = cnt_comp_q;
    cnt_raw_d  = cnt_raw_q;
    if (out_valid_q && ready_i && out_eop_q) begin
      if (out_comp_q) begin
        if (cnt_comp_q != 16'hffff) cnt_comp_d = cnt_comp_q + 16'd1;
      end else begin
        if (cnt_raw_q != 16'hffff) cnt_raw_d = cnt_raw_q + 16'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_comp_q <= 16'd0;
      cnt_raw_q  <= 16'd0;
    end else begin
      cnt_comp_q <= cnt_comp_d;
      cnt_raw_q  <= cnt_raw_d;
    end
  end

  assign cnt_comp_o = cnt_comp_q;
  assign cnt_raw_o  = cnt_raw_q;
`endif

endmodule

// File: tb/tb_aidc_lite_comp_select.sv
// Bench for aidc_lite_comp_select: block-level reference model feeding an expected-word queue,
// with a negedge monitor that drives ready_i, checks handshaked words and checks stall stability.
module tb_aidc_lite_comp_select;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, sop_i, eop_i;
  logic [63:0] data_i;
  logic        comp_valid_i;
  logic [3:0]  comp_addr_i;
  logic [63:0] comp_data_i;
  logic        comp_eop_i, comp_fail_i;
  logic        valid_o, ready_i, sop_o, eop_o, comp_o, overflow_o;
  logic [63:0] data_o;
  logic [3:0]  len_o;
`ifdef AIDC_LITE_SELECT_STATS_EN
  logic [15:0] cnt_comp, cnt_raw;
`endif

  always #5 clk = ~clk;

  aidc_lite_comp_select dut (
    .clk(clk), .rst_n(rst_n),
    .valid_i(valid_i), .sop_i(sop_i), .eop_i(eop_i), .data_i(data_i),
    .comp_valid_i(comp_valid_i), .comp_addr_i(comp_addr_i), .comp_data_i(comp_data_i),
    .comp_eop_i(comp_eop_i), .comp_fail_i(comp_fail_i),
    .valid_o(valid_o), .ready_i(ready_i), .sop_o(sop_o), .eop_o(eop_o),
    .data_o(data_o), .comp_o(comp_o), .len_o(len_o), .overflow_o(overflow_o)
`ifdef AIDC_LITE_SELECT_STATS_EN
    , .cnt_comp_o(cnt_comp), .cnt_raw_o(cnt_raw)
`endif
  );

  typedef struct packed {
    logic [63:0] d;
    logic        s;
    logic        e;
    logic        c;
    logic [3:0]  l;
  } word_t;

  int    compared = 0;
  int    mismatched = 0;
  word_t exp_q[$];
  int    rdy_mode = 0;
  int    ovf_cnt = 0;
  int    hs_cnt = 0;
  logic  prev_stall = 1'b0;
  word_t held;

  // Current block under construction
  logic [63:0] blk_raw[8];
  logic [3:0]  blk_addr[16];
  logic [63:0] blk_data[16];
  int          blk_n;
  logic        blk_fail;

  // Monitor: picks ready_i for the coming edge, scores handshakes and stall stability
  always @(negedge clk) begin
    word_t cur, ex;
    cur = {data_o, sop_o, eop_o, comp_o, len_o};
    if (!rst_n) begin
      prev_stall = 1'b0;
      ready_i = 1'b0;
    end else begin
      if (overflow_o) ovf_cnt++;
      if (prev_stall) begin
        compared++;
        if (!valid_o || cur !== held) begin
          mismatched++;
          $display("FAIL hold: valid=%0b word=%h, required valid=1 word=%h", valid_o, cur, held);
        end
      end
      case (rdy_mode)
        0: ready_i = 1'b1;
        1: ready_i = 1'b0;
        2: ready_i = ~ready_i;
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
      if (valid_o && ready_i) begin
        hs_cnt++;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL word: unexpected word %h, required none", cur);
        end else begin
          ex = exp_q.pop_front();
          if (cur !== ex) begin
            mismatched++;
            $display("FAIL word: got d=%h s=%0b e=%0b c=%0b l=%0d, required d=%h s=%0b e=%0b c=%0b l=%0d",
                     cur.d, cur.s, cur.e, cur.c, cur.l, ex.d, ex.s, ex.e, ex.c, ex.l);
          end
        end
      end
      prev_stall = valid_o && !ready_i;
      held = cur;
    end
  end

  // Reference: the block is raw if flagged or any address is out of range; else its compressed words
  task automatic model_push();
    logic        bad;
    int          maxa;
    logic [63:0] cm[8];
    word_t       w;
    bad = blk_fail;
    maxa = 0;
    for (int i = 0; i < 8; i++) cm[i] = 64'd0;
    for (int i = 0; i < blk_n; i++) begin
      if (blk_addr[i] >= 4'd8) bad = 1'b1;
      else begin
        cm[blk_addr[i]] = blk_data[i];
        if (int'(blk_addr[i]) > maxa) maxa = int'(blk_addr[i]);
      end
    end
    if (bad) begin
      for (int i = 0; i < 8; i++) begin
        w = {blk_raw[i], i == 0, i == 7, 1'b0, 4'd8};
        exp_q.push_back(w);
      end
    end else begin
      for (int i = 0; i <= maxa; i++) begin
        w = {cm[i], i == 0, i == maxa, 1'b1, 4'(maxa + 1)};
        exp_q.push_back(w);
      end
    end
  endtask

  // Random block: n compressed words covering addresses 0..n-1 in shuffled order
  task automatic gen_block(input int n, input logic fail);
    logic [3:0] t;
    int j;
    for (int i = 0; i < 8; i++) blk_raw[i] = {$urandom, $urandom};
    for (int i = 0; i < n; i++) begin
      blk_addr[i] = 4'(i);
      blk_data[i] = {$urandom, $urandom};
    end
    for (int i = n - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = blk_addr[i]; blk_addr[i] = blk_addr[j]; blk_addr[j] = t;
    end
    blk_n = n;
    blk_fail = fail;
  endtask

  // mode 0: compressed after raw; 1: comp_eop before raw eop; 2: comp_eop with raw eop
  task automatic send_block(input bit kept, input int mode);
    int e, t, s;
    case (mode)
      0: e = 8 + blk_n;
      1: e = blk_n + 1;
      default: e = 7;
    endcase
    t = (mode == 0) ? e + 1 : 8;
    s = e - blk_n;
    if (kept) model_push();
    for (int c = 0; c < t; c++) begin
      @(negedge clk);
      valid_i = (c < 8);
      sop_i = (c == 0);
      eop_i = (c == 7);
      if (c < 8) data_i = blk_raw[c];
      else data_i = {$urandom, $urandom};
      comp_valid_i = (c >= s && c < e);
      if (comp_valid_i) begin
        comp_addr_i = blk_addr[c - s];
        comp_data_i = blk_data[c - s];
      end else begin
        comp_addr_i = 4'($urandom);
        comp_data_i = {$urandom, $urandom};
      end
      comp_eop_i = (c == e);
      comp_fail_i = (c == e) ? blk_fail : 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    valid_i = 0; sop_i = 0; eop_i = 0;
    comp_valid_i = 0; comp_eop_i = 0; comp_fail_i = 0;
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain_%s: %0d words still pending, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_block(input int max_mode);
    int mode, n;
    mode = $urandom_range(0, max_mode);
    n = (mode == 0) ? $urandom_range(1, 8) : (mode == 1) ? $urandom_range(1, 5) : $urandom_range(1, 6);
    gen_block(n, 1'($urandom_range(0, 3) == 0));
    send_block(1'b1, mode);
  endtask

  task automatic test_reset();
    rst_n = 0;
    valid_i = 0; sop_i = 0; eop_i = 0; data_i = 0;
    comp_valid_i = 0; comp_addr_i = 0; comp_data_i = 0; comp_eop_i = 0; comp_fail_i = 0;
    repeat (3) @(negedge clk);
    compared++;
    if ({valid_o, sop_o, eop_o, comp_o, len_o, overflow_o} !== 9'd0 || data_o !== 64'd0) begin
      mismatched++;
      $display("FAIL reset: v=%0b s=%0b e=%0b c=%0b l=%0d o=%0b d=%h, required all 0",
               valid_o, sop_o, eop_o, comp_o, len_o, overflow_o, data_o);
    end
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_block();
    rdy_mode = 0;
    for (int i = 0; i < 8; i++) blk_raw[i] = 64'd0;
    blk_addr[0] = 4'd0; blk_data[0] = 64'd0; blk_n = 1; blk_fail = 0;
    send_block(1'b1, 0);
    idle();
    wait_drain("zero");
  endtask

  task automatic test_raw_fail();
    rdy_mode = 0;
    gen_block($urandom_range(1, 8), 1'b1);
    send_block(1'b1, 0);
    idle();
    wait_drain("rawfail");
    blk_addr[0] = 4'd0; blk_addr[1] = 4'd1; blk_addr[2] = 4'd12;
    blk_n = 3; blk_fail = 0;
    send_block(1'b1, 0);
    idle();
    wait_drain("badaddr");
  endtask

  task automatic test_comp_early();
    rdy_mode = 0;
    gen_block(5, 1'b0);
    send_block(1'b1, 1);
    idle();
    wait_drain("early");
    gen_block(6, 1'b0);
    send_block(1'b1, 2);
    idle();
    wait_drain("same");
  endtask

  task automatic test_drop();
    ovf_cnt = 0;
    rdy_mode = 1;
    gen_block(6, 1'b0); send_block(1'b1, 2);
    gen_block(4, 1'b1); send_block(1'b1, 2);
    gen_block(3, 1'b0); send_block(1'b0, 2);
    idle();
    repeat (5) @(negedge clk);
    compared++;
    if (ovf_cnt != 1) begin
      mismatched++;
      $display("FAIL drop_ovf: %0d pulses, required 1", ovf_cnt);
    end
    compared++;
    if (valid_o !== 1'b1 || sop_o !== 1'b1) begin
      mismatched++;
      $display("FAIL drop_stall: valid=%0b sop=%0b, required 1 1", valid_o, sop_o);
    end
    rdy_mode = 0;
    wait_drain("drop");
    compared++;
    if (ovf_cnt != 1) begin
      mismatched++;
      $display("FAIL drop_ovf_end: %0d pulses, required 1", ovf_cnt);
    end
  endtask

  task automatic test_traffic(input int mode_rdy, input int pairs, input string tag);
    ovf_cnt = 0;
    rdy_mode = mode_rdy;
    for (int p = 0; p < pairs; p++) begin
      rand_block(2);
      rand_block(2);
      idle();
      wait_drain(tag);
    end
    compared++;
    if (ovf_cnt != 0) begin
      mismatched++;
      $display("FAIL %s_ovf: %0d pulses, required 0", tag, ovf_cnt);
    end
  endtask

  task automatic test_reset_mid_drain();
    int h0, k;
    rdy_mode = 2;
    gen_block(4, 1'b1);
    send_block(1'b1, 0);
    idle();
    h0 = hs_cnt;
    k = 0;
    while (hs_cnt < h0 + 3 && k < 500) begin
      @(negedge clk);
      k++;
    end
    compared++;
    if (hs_cnt < h0 + 3) begin
      mismatched++;
      $display("FAIL middrain_start: %0d words, required 3", hs_cnt - h0);
    end
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    compared++;
    if (valid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL middrain_valid: valid=%0b, required 0", valid_o);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    rdy_mode = 0;
    gen_block(7, 1'b0);
    send_block(1'b1, 0);
    idle();
    wait_drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_zero_block();
    test_raw_fail();
    test_comp_early();
    test_drop();
    test_traffic(2, 3, "toggle");
    test_traffic(3, 5, "random");
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/aidc_lite_comp_select.md
AIDC_LITE_COMP_SELECT -- requirements
Module: aidc_lite_comp_select

Interface
REQ-001 SHALL have port clk, input, 1, sole clock.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port valid_i/sop_i/eop_i, input, 1 each, raw-beat strobes from the compressor input; no backpressure.
REQ-004 SHALL have port data_i, input, 64, raw beat; a block is 8 beats, sop on beat 0, eop on beat 7.
REQ-005 SHALL have port comp_valid_i, input, 1, compressed-word strobe.
REQ-006 SHALL have port comp_addr_i, input, 4, compressed-word index.
REQ-007 SHALL have port comp_data_i, input, 64, compressed word.
REQ-008 SHALL have port comp_eop_i, input, 1, marks the cycle after the block's last compressed word; comp_fail_i sampled here.
REQ-009 SHALL have port comp_fail_i, input, 1, compressed size exceeds 512 bits.
REQ-010 SHALL have port valid_o/ready_i, output/input, 1 each, output handshake.
REQ-011 SHALL have port sop_o/eop_o, output, 1 each, block delimiters.
REQ-012 SHALL have port data_o, output, 64, output word.
REQ-013 SHALL have port comp_o, output, 1, block is compressed (1) or raw (0); constant over a block.
REQ-014 SHALL have port len_o, output, 4, word count of current block, 1..8.
REQ-015 SHALL have port overflow_o, output, 1, one-cycle pulse when a raw block is dropped.

Function
REQ-016 SHALL hold two banks (raw 8x64 + comp 8x64 + fail + len each); bank state EMPTY->FILL->FULL->DRAIN->EMPTY.
REQ-017 SHALL write raw beats into the raw-write bank; sop moves it EMPTY->FILL and resets its beat index to 0; eop at index 7 arms raw_done.
REQ-018 SHALL drop the whole block and pulse overflow_o when sop arrives and the target bank is not EMPTY.
REQ-019 SHALL ignore valid_i beats without sop while not in FILL; a sop mid-FILL restarts the block at index 0.
REQ-020 SHALL push a kept/dropped tag per sop into a 4-deep tag FIFO; comp_eop_i pops it; dropped-tag comp words are discarded.
REQ-021 SHALL write comp_data_i at comp_addr_i into the comp-write bank; addr>=8 writes are discarded and force fail.
REQ-022 SHALL set bank len = max written comp addr + 1 at comp_eop_i if not fail, else 8.
REQ-023 SHALL move a bank to FULL when both raw_done and comp_eop are seen, in either order or the same cycle; raw and comp write pointers toggle independently.
REQ-024 SHALL drain banks in block order; valid_o rises the cycle after FULL; one word per ready_i&valid_o.
REQ-025 SHALL output comp words when fail=0 (comp_o=1), raw beats when fail=1 (comp_o=0); sop_o on word 0, eop_o on word len-1.
REQ-026 SHALL hold data_o/sop_o/eop_o/comp_o/len_o stable while valid_o&!ready_i.
REQ-027 SHALL free a bank (EMPTY) in the cycle after its eop_o handshake; back-to-back banks drain without bubble.
REQ-028 SHALL tolerate raw fill of one bank concurrent with drain of the other.

Reset
REQ-029 SHALL on rst_n low clear all bank states to EMPTY, pointers, tag FIFO, valid_o, sop_o, eop_o, comp_o, len_o, overflow_o, data_o to 0.
REQ-030 SHALL abandon any in-flight block on reset; the first accepted block after reset requires a new sop.

Configuration
REQ-031 SHALL, with AIDC_LITE_SELECT_STATS_EN defined, add outputs cnt_comp_o[15:0] and cnt_raw_o[15:0], saturating counts of blocks emitted compressed/raw, incremented on eop_o handshake, reset to 0.
REQ-032 SHALL, without AIDC_LITE_SELECT_STATS_EN, omit those ports and counters; other behaviour identical.

Verification
REQ-033 SHALL test all-zero block, comp words addr 0 only, fail=0 -> one word, sop_o=eop_o=1, comp_o=1, len_o=1.
REQ-034 SHALL test random block, fail=1 -> 8 raw beats equal to data_i in order, comp_o=0, len_o=8.
REQ-035 SHALL test 3 blocks back-to-back with ready_i=0 throughout -> third sop drops, overflow_o pulses once, the two kept blocks then drain intact.
REQ-036 SHALL test ready_i toggling every cycle -> each word held until handshake; no loss or duplication.
REQ-037 SHALL test comp_eop_i arriving before raw eop, and in the same cycle -> block emitted after both, len correct.
REQ-038 SHALL test rst_n asserted mid-drain -> valid_o=0 immediately; next block output correct.
